display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_pkg.sv | 14 +
 rtl/display_scanner_dec.sv | 30 +++
 rtl/display_scanner.sv | 147 ++++++++++++++
 tb/tb_display_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan states and default timing for the display scanner
package display_pkg;

    localparam int NDIG_DEF    = 4;
    localparam int ON_CYC_DEF  = 1000;
    localparam int GAP_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_scanner_dec.sv
// rtl/display_scanner_dec.sv - hex nibble to seven-segment decoder, bit order {a,f,b,g,e,c,d}
module display_scanner_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'h0: seg = 7'b1110111;
            4'h1: seg = 7'b0010010;
            4'h2: seg = 7'b1011101;
            4'h3: seg = 7'b1011011;
            4'h4: seg = 7'b0111010;
            4'h5: seg = 7'b1101011;
            4'h6: seg = 7'b1101111;
            4'h7: seg = 7'b1010010;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'ha: seg = 7'b1111110;
            4'hb: seg = 7'b0101111;
            4'hc: seg = 7'b1100101;
            4'hd: seg = 7'b0011111;
            4'he: seg = 7'b1101101;
            4'hf: seg = 7'b1101100;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed seven-segment scanner with tear-free double-buffered contents
module display_scanner
    import display_pkg::*;
#(
    parameter int NDIG    = NDIG_DEF,
    parameter int ON_CYC  = ON_CYC_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]   wr_blank,
    input  logic [NDIG-1:0]   wr_dp,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        s,
    output logic              dp,
    output logic              frame_done
);

    localparam int CW = $clog2(ON_CYC > GAP_CYC ? ON_CYC : GAP_CYC);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    scan_state_e       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              boundary;
    logic              pend;
    logic              accept;
    logic              load;
    logic [4*NDIG-1:0] shadow_data, pending_data;
    logic [NDIG-1:0]   shadow_blank, pending_blank;
    logic [NDIG-1:0]   shadow_dp, pending_dp;
    logic [6:0]        seg_raw;

    assign wr_ready = ~pend;
    assign accept   = wr_valid & ~pend;
    // Shadow only ever moves at a frame boundary or while dark, so a frame never tears.
    assign load     = pend & (boundary | (state_q == ST_OFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            frame_done <= boundary;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= 1'b0;
            pending_data  <= '0;
            pending_blank <= '0;
            pending_dp    <= '0;
            shadow_data   <= '0;
            shadow_blank  <= '0;
            shadow_dp     <= '0;
        end else if (accept) begin
            pending_data  <= wr_data;
            pending_blank <= wr_blank;
            pending_dp    <= wr_dp;
            pend          <= 1'b1;
        end else if (load) begin
            shadow_data   <= pending_data;
            shadow_blank  <= pending_blank;
            shadow_dp     <= pending_dp;
            pend          <= 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        case (state_q)
            ST_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                if (enable) state_d = ST_ON;
            end
            ST_ON: begin
                if (!enable) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    display_scanner_dec u_dec (
        .nibble (shadow_data[{idx_q, 2'b00} +: 4]),
        .seg    (seg_raw)
    );

    always_comb begin
        an = '1;
        s  = 7'b0000000;
        dp = 1'b0;
        if (state_q == ST_ON) begin
            an[idx_q] = 1'b0;
            s         = shadow_blank[idx_q] ? 7'b0000000 : seg_raw;
            dp        = shadow_dp[idx_q];
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - scoreboard bench for display_scanner with NDIG=4, ON_CYC=4, GAP_CYC=2
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_blank;
    logic [3:0]  wr_dp;
    logic [3:0]  an;
    logic [6:0]  s;
    logic        dp;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] s;
        logic       sv;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   errors;

    display_scanner #(.NDIG(4), .ON_CYC(4), .GAP_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_blank   (wr_blank),
        .wr_dp      (wr_dp),
        .an         (an),
        .s          (s),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Only glyphs whose bit pattern is fixed by known reference digits are checked.
    function automatic logic [7:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h3:    return {1'b1, 7'b1011011};
            4'h4:    return {1'b1, 7'b0111010};
            4'h8:    return {1'b1, 7'b1111111};
            4'ha:    return {1'b1, 7'b1111110};
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_n(input logic [3:0] a, input logic [6:0] sg, input logic sv, input logic d, input int n);
        exp_t e;
        e.an = a; e.s = sg; e.sv = sv; e.dp = d;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] dpv);
        logic [7:0] r;
        logic [3:0] a;
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            r = seg_ref(d[4*i +: 4]);
            if (bl[i]) r = {1'b1, 7'b0000000};
            push_n(a, r[6:0], r[7], dpv[i], 4);
            push_n(4'b1111, 7'b0000000, 1'b1, 1'b0, 2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            step();
            check("sb_level", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("an@%0t", $time), {28'd0, an}, {28'd0, e.an});
                check($sformatf("dp@%0t", $time), {31'd0, dp}, {31'd0, e.dp});
                if (e.sv) check($sformatf("s@%0t", $time), {25'd0, s}, {25'd0, e.s});
            end
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, {28'd0, an}, 32'hf);
        check({tag, "_s"}, {25'd0, s}, 32'd0);
        check({tag, "_dp"}, {31'd0, dp}, 32'd0);
    endtask

    initial begin
        int n;
        logic found;
        tests    = 0;
        errors   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0;
        wr_blank = 4'h0;
        wr_dp    = 4'h0;

        #3;
        check_dark("rst");
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_dark("off");

        // load 1234 while dark: one edge to pending, the next edge into shadow
        wr_data  = 16'h1234;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("off_ready_busy", {31'd0, wr_ready}, 32'd0);
        step();
        check("off_ready_back", {31'd0, wr_ready}, 32'd1);

        enable = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0);
        run(24);

        // mid-frame update with a second write held behind it
        push_frame(16'h1234, 4'h0, 4'h0);
        run(6);
        wr_data  = 16'habcd;
        wr_valid = 1'b1;
        run(1);
        check("mid_ready_busy", {31'd0, wr_ready}, 32'd0);
        wr_data = 16'h8888;
        run(17);
        check("mid_ready_hold", {31'd0, wr_ready}, 32'd0);
        push_frame(16'habcd, 4'h0, 4'h0);
        push_frame(16'h8888, 4'h0, 4'h0);
        run(1);
        check("bnd_ready", {31'd0, wr_ready}, 32'd1);
        run(1);
        check("second_accept", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        run(22);
        run(1);
        check("second_applied", {31'd0, wr_ready}, 32'd1);
        run(23);

        // drop enable during digit 2
        push_frame(16'h8888, 4'h0, 4'h0);
        run(14);
        enable = 1'b0;
        sb.delete();
        push_n(4'b1111, 7'b0000000, 1'b1, 1'b0, 3);
        run(1);
        check("drop_fd", {31'd0, frame_done}, 32'd0);
        run(2);

        wr_data  = 16'h8888;
        wr_blank = 4'b0010;
        wr_dp    = 4'b0001;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("bl_ready_busy", {31'd0, wr_ready}, 32'd0);
        step();
        check("bl_ready_back", {31'd0, wr_ready}, 32'd1);
        enable = 1'b1;
        push_frame(16'h8888, 4'b0010, 4'b0001);
        run(24);

        // frame_done period and width
        for (int k = 0; k < 2; k++) begin
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                step();
                found = frame_done;
            end
            check("fd_seen", {31'd0, found}, 32'd1);
            step();
            check("fd_width", {31'd0, frame_done}, 32'd0);
            n = 1;
            while (!frame_done && n < 40) begin
                step();
                n++;
            end
            check("fd_period", n, 32'd24);
        end

        // asynchronous reset while lit, with a write pending
        wr_data  = 16'h1234;
        wr_blank = 4'h0;
        wr_dp    = 4'h0;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("pre_rst_busy", {31'd0, wr_ready}, 32'd0);
        check("pre_rst_lit", {31'd0, an != 4'hf}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        check("async_rst_ready", {31'd0, wr_ready}, 32'd1);
        check("async_rst_fd", {31'd0, frame_done}, 32'd0);
        step();
        rst_n = 1'b1;
        push_frame(16'h0000, 4'h0, 4'h0);
        run(24);
        check("post_rst_ready", {31'd0, wr_ready}, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
